// File: rtl/pilha_param.sv
// Parametrised operand stack: LIFO with dual push sources, binary-op replace,
// DUP/SWAP/CLEAR, combinational TOS/NOS taps and sticky error flags.

module pilha_cell #(
  parameter int              WIDTH = 8,
  parameter int              CW    = 5,
  parameter logic [CW-1:0]   ID    = '0
) (
  input  logic             clock,
  input  logic             we0,
  input  logic [CW-1:0]    a0,
  input  logic [WIDTH-1:0] d0,
  input  logic             we1,
  input  logic [CW-1:0]    a1,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] q
);
  // Storage is deliberately not reset; indice alone defines what is valid.
  always_ff @(posedge clock) begin
    if (we0 && a0 == ID)      q <= d0;
    else if (we1 && a1 == ID) q <= d1;
  end
endmodule

module pilha_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din_UC,
  input  logic [WIDTH-1:0] din_ULA,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout2,
  output logic [CW-1:0]    indice,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH_UC, OP_PUSH_ULA, OP_POP,
    OP_REPLACE2, OP_DUP, OP_SWAP, OP_CLEAR
  } op_e;

  typedef struct packed {
    logic             en;
    logic [CW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wport_t;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] TWO = CW'(2);
  localparam logic [CW-1:0] DEP = CW'(DEPTH);

  op_e                         opc;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [CW-1:0]               tos_idx, nos_idx, ind_n;
  logic [WIDTH-1:0]            tos, nos;
  logic                        ovf_set, udf_set;
  wport_t                      wp0, wp1;

  assign opc     = op_e'(op);
  assign tos_idx = indice - ONE;
  assign nos_idx = indice - TWO;
  assign empty   = (indice == '0);
  assign full    = (indice == DEP);
  assign dout    = tos;
  assign dout2   = nos;

  always_comb begin
    tos = '0;
    nos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (indice >= ONE && tos_idx == CW'(i)) tos = mem[i];
      if (indice >= TWO && nos_idx == CW'(i)) nos = mem[i];
    end
  end

  // Two write ports: SWAP is the only op that touches two entries.
  always_comb begin
    ind_n   = indice;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    wp0     = '0;
    wp1     = '0;
    case (opc)
      OP_PUSH_UC, OP_PUSH_ULA: begin
        if (full) ovf_set = 1'b1;
        else begin
          wp0   = '{1'b1, indice, (opc == OP_PUSH_UC) ? din_UC : din_ULA};
          ind_n = indice + ONE;
        end
      end
      OP_POP: begin
        if (empty) udf_set = 1'b1;
        else       ind_n   = tos_idx;
      end
      OP_REPLACE2: begin
        if (indice < TWO) udf_set = 1'b1;
        else begin
          wp0   = '{1'b1, nos_idx, din_ULA};
          ind_n = tos_idx;
        end
      end
      OP_DUP: begin
        // Empty takes priority: nothing to duplicate is an underflow.
        if (empty)     udf_set = 1'b1;
        else if (full) ovf_set = 1'b1;
        else begin
          wp0   = '{1'b1, indice, tos};
          ind_n = indice + ONE;
        end
      end
      OP_SWAP: begin
        if (indice < TWO) udf_set = 1'b1;
        else begin
          wp0 = '{1'b1, tos_idx, nos};
          wp1 = '{1'b1, nos_idx, tos};
        end
      end
      OP_CLEAR: ind_n = '0;
      default: ;
    endcase
  end

  // Writes are gated by reset so an edge seen while in reset changes nothing.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    pilha_cell #(.WIDTH(WIDTH), .CW(CW), .ID(CW'(i))) u_cell (
      .clock (clock),
      .we0   (wp0.en & reset),
      .a0    (wp0.addr),
      .d0    (wp0.data),
      .we1   (wp1.en & reset),
      .a1    (wp1.addr),
      .d1    (wp1.data),
      .q     (mem[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      indice    <= ind_n;
      overflow  <= ovf_set | (overflow  & ~err_clr);
      underflow <= udf_set | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_pilha_param.sv
// Bench for pilha_param: queue-based stack model compared every cycle, plus
// directed scenarios with literal expectations and randomized op streams.

module tb_pilha_param;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  din_UC = '0, din_ULA = '0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  dout, dout2;
  logic [CW-1:0] indice;
  logic          empty, full, overflow, underflow;

  pilha_param #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .op(op), .din_UC(din_UC), .din_ULA(din_ULA),
    .err_clr(err_clr), .dout(dout), .dout2(dout2), .indice(indice),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int q[$];
  bit m_ovf = 1'b0, m_udf = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_tos();
    return (q.size() >= 1) ? q[q.size()-1] : 0;
  endfunction

  function automatic int m_nos();
    return (q.size() >= 2) ? q[q.size()-2] : 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] o, input int uc, input int ula, input bit clr);
    bit ov = 0, un = 0;
    int n = q.size();
    int t;
    case (o)
      3'd1: if (n == D) ov = 1; else q.push_back(uc);
      3'd2: if (n == D) ov = 1; else q.push_back(ula);
      3'd3: if (n == 0) un = 1; else void'(q.pop_back());
      3'd4: if (n < 2) un = 1; else begin
              void'(q.pop_back()); void'(q.pop_back()); q.push_back(ula);
            end
      3'd5: if (n == 0) un = 1; else if (n == D) ov = 1; else q.push_back(q[n-1]);
      3'd6: if (n < 2) un = 1; else begin
              t = q[n-1]; q[n-1] = q[n-2]; q[n-2] = t;
            end
      3'd7: q.delete();
      default: ;
    endcase
    m_ovf = ov | (m_ovf & !clr);
    m_udf = un | (m_udf & !clr);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_indice", 32'(indice), q.size());
      check("cmp_dout", 32'(dout), m_tos());
      check("cmp_dout2", 32'(dout2), m_nos());
      check("cmp_empty", 32'(empty), q.size() == 0);
      check("cmp_full", 32'(full), q.size() == D);
      check("cmp_overflow", 32'(overflow), m_ovf);
      check("cmp_underflow", 32'(underflow), m_udf);
    end
  end

  task automatic step(input logic [2:0] o, input logic [W-1:0] uc, input logic [W-1:0] ula,
                      input bit clr);
    @(negedge clock); #1;
    op = o; din_UC = uc; din_ULA = ula; err_clr = clr;
    @(posedge clock);
    model_apply(o, uc, ula, clr);
    #1;
    op = 3'd0; err_clr = 1'b0;
  endtask

  // Reset asserted between edges with a live op, held across one edge.
  task automatic pulse_reset(input logic [2:0] o);
    @(negedge clock); #2;
    op = o; din_UC = W'($urandom); din_ULA = W'($urandom);
    reset = 1'b0;
    model_reset();
    #1;
    check("async_indice", 32'(indice), 0);
    check("async_flags", {30'd0, overflow, underflow}, 0);
    @(posedge clock); #1;
    check("rst_held_indice", 32'(indice), 0);
    @(negedge clock); #2;
    reset = 1'b1;
    op = 3'd0;
  endtask

  initial begin
    int r;
    logic [2:0] o;
    model_reset();
    #12 reset = 1'b1;
    chk_en = 1'b1;

    // Reset mid-stream, then two pushes.
    step(3'd1, 8'hAA, 8'h00, 0);
    step(3'd1, 8'hBB, 8'h00, 0);
    pulse_reset(3'd1);
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_empty", 32'(empty), 1);
    step(3'd1, 8'h11, 8'h00, 0);
    step(3'd1, 8'h22, 8'h00, 0);
    check("push_indice", 32'(indice), 2);
    check("push_dout", 32'(dout), 32'h22);
    check("push_dout2", 32'(dout2), 32'h11);
    check("push_empty", 32'(empty), 0);

    // Fill and overflow.
    step(3'd7, 8'h00, 8'h00, 0);
    for (int i = 1; i <= 4; i++) step(3'd1, W'(i), 8'h00, 0);
    step(3'd2, 8'h00, 8'h55, 0);
    check("ovf_full", 32'(full), 1);
    check("ovf_indice", 32'(indice), 4);
    check("ovf_dout", 32'(dout), 4);
    check("ovf_dout2", 32'(dout2), 3);
    check("ovf_flag", 32'(overflow), 1);
    step(3'd0, 8'h00, 8'h00, 1);
    check("ovf_clr", 32'(overflow), 0);

    // Binary-op replace.
    step(3'd7, 8'h00, 8'h00, 0);
    step(3'd1, 8'd7, 8'h00, 0);
    step(3'd1, 8'd5, 8'h00, 0);
    step(3'd4, 8'h00, 8'd12, 0);
    check("rep_indice", 32'(indice), 1);
    check("rep_dout", 32'(dout), 12);
    check("rep_dout2", 32'(dout2), 0);
    check("rep_flags", {30'd0, overflow, underflow}, 0);

    // DUP / SWAP.
    step(3'd7, 8'h00, 8'h00, 0);
    step(3'd1, 8'd3, 8'h00, 0);
    step(3'd5, 8'h00, 8'h00, 0);
    check("dup_indice", 32'(indice), 2);
    check("dup_dout2", 32'(dout2), 3);
    step(3'd1, 8'd9, 8'h00, 0);
    step(3'd6, 8'h00, 8'h00, 0);
    check("swap_dout", 32'(dout), 3);
    check("swap_dout2", 32'(dout2), 9);
    check("swap_indice", 32'(indice), 3);

    // Underflow handling and err_clr priority.
    step(3'd7, 8'h00, 8'h00, 0);
    step(3'd3, 8'h00, 8'h00, 0);
    check("udf_flag", 32'(underflow), 1);
    check("udf_indice", 32'(indice), 0);
    step(3'd1, 8'd8, 8'h00, 0);
    step(3'd6, 8'h00, 8'h00, 0);
    check("udf_swap_flag", 32'(underflow), 1);
    check("udf_swap_dout", 32'(dout), 8);
    step(3'd3, 8'h00, 8'h00, 0);
    step(3'd3, 8'h00, 8'h00, 1);
    check("udf_setwins", 32'(underflow), 1);
    step(3'd1, 8'd1, 8'h00, 1);
    check("clr_legal_flag", 32'(underflow), 0);
    check("clr_legal_indice", 32'(indice), 1);
    step(3'd0, 8'h00, 8'h00, 0);
    step(3'd5, 8'h00, 8'h00, 0);
    step(3'd5, 8'h00, 8'h00, 0);
    step(3'd5, 8'h00, 8'h00, 0);
    step(3'd5, 8'h00, 8'h00, 0);
    check("dup_full_ovf", 32'(overflow), 1);
    check("dup_full_udf", 32'(underflow), 0);
    step(3'd7, 8'h00, 8'h00, 1);
    step(3'd5, 8'h00, 8'h00, 0);
    check("dup_empty_udf", 32'(underflow), 1);
    check("dup_empty_ovf", 32'(overflow), 0);

    // Async reset on a populated stack with a flag set.
    step(3'd7, 8'h00, 8'h00, 0);
    step(3'd3, 8'h00, 8'h00, 0);
    for (int i = 1; i <= 3; i++) step(3'd1, W'(i), 8'h00, 0);
    check("pre_rst_udf", 32'(underflow), 1);
    pulse_reset(3'd4);
    for (int i = 1; i <= 5; i++) step(3'd1, W'(i), 8'h00, 0);
    check("pre_clear_ovf", 32'(overflow), 1);
    step(3'd7, 8'h00, 8'h00, 0);
    check("clear_indice", 32'(indice), 0);
    check("clear_keeps_ovf", 32'(overflow), 1);

    // Randomized op stream.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset(3'($urandom_range(0, 7)));
      r = $urandom_range(0, 15);
      o = (r < 5) ? 3'd1 : (r < 7) ? 3'd2 : (r < 9) ? 3'd3 : (r < 11) ? 3'd4 :
          (r < 12) ? 3'd5 : (r < 14) ? 3'd6 : (r < 15) ? 3'd0 : 3'd7;
      step(o, W'($urandom), W'($urandom), $urandom_range(0, 7) == 0);
    end

    @(negedge clock); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pilha_param.md
Name: pilha_param

Overview:
- Parametrised successor to the processor's operand stack (pilha).
- Synchronous LIFO with configurable data width and depth.
- Supports pushes from both the control unit (UC) and the ALU (ULA), plus POP, binary-op replace, DUP, SWAP and CLEAR.
- Exposes the top two entries combinationally for the ULA and temp registers, and reports full/empty state and sticky overflow/underflow flags to the UC.

Parameters:
- WIDTH, 8: data word width in bits.
- DEPTH, 16: maximum number of entries; must be 2 or more.
- CW, $clog2(DEPTH+1): count width (derived, localparam).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  3  stack operation; encoding is given under Behaviour.
- din_UC  in  WIDTH  push data from the control unit.
- din_ULA  in  WIDTH  push/replace data from the ALU.
- err_clr  in  1  clears the sticky error flags.
- dout  out  WIDTH  top of stack (TOS).
- dout2  out  WIDTH  second entry (NOS).
- indice  out  CW  current entry count, 0..DEPTH.
- empty  out  1  high when indice == 0.
- full  out  1  high when indice == DEPTH.
- overflow  out  1  sticky flag: an illegal grow was attempted.
- underflow  out  1  sticky flag: an illegal shrink or read was attempted.

Behaviour:
- Reset (reset low, asynchronous):
  - indice=0, overflow=0, underflow=0.
  - Hence dout=0, dout2=0, empty=1, full=0.
  - Storage array is not cleared.
  - Reset asserted mid-operation aborts the op; no partial update survives.
- Outputs are combinational from registered state:
  - dout = mem[indice-1] when indice>=1, else 0.
  - dout2 = mem[indice-2] when indice>=2, else 0.
  - empty and full are decoded from indice.
- Latency: op sampled at edge N; the result is visible on the outputs after edge N. Ops are single-cycle and back-to-back with no bubbles.
- Op encoding (op = 0 to 7):
  - 0 NOP: no change.
  - 1 PUSH_UC: mem[indice] <= din_UC; indice +1. Requires !full.
  - 2 PUSH_ULA: as PUSH_UC but writes din_ULA.
  - 3 POP: indice -1. Requires indice>=1.
  - 4 REPLACE2: pop two, push din_ULA. mem[indice-2] <= din_ULA; indice -1. Requires indice>=2.
  - 5 DUP: mem[indice] <= TOS; indice +1. Requires 1<=indice<DEPTH.
  - 6 SWAP: exchange mem[indice-1] and mem[indice-2]; indice unchanged. Requires indice>=2.
  - 7 CLEAR: indice <= 0. Flags are unaffected.
- Illegal-op rules:
  - An op whose requirement fails leaves mem and indice unchanged (NOP).
  - Grow when full (PUSH_UC, PUSH_ULA, DUP at DEPTH) sets overflow.
  - Shrink or read without enough operands (POP at 0; REPLACE2 or SWAP below 2; DUP at 0) sets underflow.
  - DUP at 0 is underflow, not overflow.
- Flags are sticky:
  - Cleared only by reset or by err_clr=1 at an edge.
  - If err_clr coincides with a new error, the flag ends up set (set wins).
  - err_clr coincident with a legal op: the op executes and the flags clear.
- Boundaries:
  - indice never exceeds DEPTH and never wraps below 0.
  - PUSH at DEPTH-1 sets full after the edge.
  - POP at 1 sets empty after the edge.
- Arithmetic: all index math is in CW bits. Data is never modified; REPLACE2 stores din_ULA verbatim.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4.
- Reset then push: hold reset low mid-stream, release, PUSH_UC 0x11, PUSH_UC 0x22 -> after reset dout=0, empty=1; then indice=2, dout=0x22, dout2=0x11, empty=0.
- Fill and overflow: 4x PUSH_UC (1,2,3,4) then PUSH_ULA 0x55 -> full=1, indice=4, dout=4, overflow=1, contents unchanged. Then err_clr=1 with NOP -> overflow=0.
- Binary op: stack [7,5] (TOS 5), din_ULA=12, REPLACE2 -> indice=1, dout=12, dout2=0, no flags set.
- DUP/SWAP: stack [3], DUP -> [3,3]; PUSH_UC 9, SWAP -> dout=3, dout2=9, indice=3.
- Underflow: empty stack, POP -> underflow=1, indice=0. Then [8] with SWAP -> underflow stays 1, dout=8. err_clr together with a POP on an empty stack -> underflow remains 1.
- Async reset mid-op: stack [1,2,3], drive reset low between edges -> indice=0 and flags=0 immediately, with no clock edge needed. CLEAR on a full stack with overflow=1 -> indice=0, overflow stays 1.
